// File: rtl/cpu_gregs_mp.sv
// cpu_gregs_mp: 2R/1W general register file, x0 hardwired to zero,
// write-first bypass, registered debug port and post-reset init sequencer.
module cpu_gregs_mp #(
  parameter int          XLEN       = 32,
  parameter int          GREG_COUNT = 32,
  parameter int          IDX_WIDTH  = 5,
  parameter int          SP_IDX     = 2,
  parameter logic [31:0] SP_INIT    = 32'h0007fff0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rs1_ren,
  input  logic [IDX_WIDTH-1:0] rs1_idx,
  output logic [XLEN-1:0]      rs1_dat,
  input  logic                 rs2_ren,
  input  logic [IDX_WIDTH-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs2_dat,
  input  logic                 rd_wen,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  input  logic [XLEN-1:0]      rd_dat,
  input  logic [IDX_WIDTH-1:0] dbg_idx,
  output logic [XLEN-1:0]      dbg_dat,
  output logic                 init_busy
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [XLEN-1:0] SP_VAL =
    XLEN'(SP_INIT);
  localparam logic [IDX_WIDTH-1:0] SP_I =
    IDX_WIDTH'(SP_IDX);
  localparam logic [IDX_WIDTH-1:0] LAST_I =
    IDX_WIDTH'(GREG_COUNT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WIDTH-1:0] r_init_cnt;
  logic [IDX_WIDTH-1:0] w_init_cnt_nxt;

  logic [XLEN-1:0]      r_mem [GREG_COUNT];
  logic                 w_we;
  logic [IDX_WIDTH-1:0] w_waddr;
  logic [XLEN-1:0]      w_wdata;

  logic [XLEN-1:0]      r_rs1_dat;
  logic [XLEN-1:0]      r_rs2_dat;
  logic [XLEN-1:0]      r_dbg_dat;
  logic [XLEN-1:0]      w_rs1_val;
  logic [XLEN-1:0]      w_rs2_val;
  logic [XLEN-1:0]      w_dbg_val;

  function automatic logic [XLEN-1:0] f_rdval(
    input logic [IDX_WIDTH-1:0] idx,
    input logic [XLEN-1:0]      mem_val,
    input logic                 wen,
    input logic [IDX_WIDTH-1:0] widx,
    input logic [XLEN-1:0]      wdat
  );
    if (idx == '0)
      return '0;
    else if (wen && (widx == idx))
      return wdat;
    else
      return mem_val;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_we           = 1'b0;
    w_waddr        = rd_idx;
    w_wdata        = rd_dat;
    unique case (r_state)
      S_INIT: begin
        w_we           = 1'b1;
        w_waddr        = r_init_cnt;
        w_wdata        = (r_init_cnt == SP_I) ?
                         SP_VAL : '0;
        w_init_cnt_nxt = r_init_cnt +
                         IDX_WIDTH'(1);
        if (r_init_cnt == LAST_I)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_we = rd_wen && (rd_idx != '0);
      end
    endcase
  end

  // Array has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  assign w_rs1_val = f_rdval(rs1_idx,
    r_mem[rs1_idx], rd_wen, rd_idx, rd_dat);
  assign w_rs2_val = f_rdval(rs2_idx,
    r_mem[rs2_idx], rd_wen, rd_idx, rd_dat);
  assign w_dbg_val = f_rdval(dbg_idx,
    r_mem[dbg_idx], rd_wen, rd_idx, rd_dat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs1_dat <= '0;
      r_rs2_dat <= '0;
      r_dbg_dat <= '0;
    end else if (r_state == S_RUN) begin
      if (rs1_ren)
        r_rs1_dat <= w_rs1_val;
      if (rs2_ren)
        r_rs2_dat <= w_rs2_val;
      r_dbg_dat <= w_dbg_val;
    end
  end

  assign rs1_dat   = r_rs1_dat;
  assign rs2_dat   = r_rs2_dat;
  assign dbg_dat   = r_dbg_dat;
  assign init_busy = (r_state == S_INIT);

endmodule

// File: tb/tb_cpu_gregs_mp.sv
// tb_cpu_gregs_mp: scoreboard bench for cpu_gregs_mp.
// Expected read data is queued at drive time, compared a cycle later.
module tb_cpu_gregs_mp;

  localparam logic [31:0] SP = 32'h0007fff0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rs1_ren;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_dat;
  logic        rs2_ren;
  logic [4:0]  rs2_idx;
  logic [31:0] rs2_dat;
  logic        rd_wen;
  logic [4:0]  rd_idx;
  logic [31:0] rd_dat;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_dat;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] qd [$];
  logic [31:0] m  [32];

  cpu_gregs_mp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rs1_ren   (rs1_ren),
    .rs1_idx   (rs1_idx),
    .rs1_dat   (rs1_dat),
    .rs2_ren   (rs2_ren),
    .rs2_idx   (rs2_idx),
    .rs2_dat   (rs2_dat),
    .rd_wen    (rd_wen),
    .rd_idx    (rd_idx),
    .rd_dat    (rd_dat),
    .dbg_idx   (dbg_idx),
    .dbg_dat   (dbg_dat),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic model_init();
    for (int i = 0; i < 32; i++) m[i] = '0;
    m[2] = SP;
  endtask

  task automatic idle();
    rs1_ren = 0; rs2_ren = 0; rd_wen = 0;
    rs1_idx = 0; rs2_idx = 0; rd_idx = 0;
    rd_dat = 0; dbg_idx = 0;
  endtask

  // Waits out init, checking outputs stay 0 and it lasts 32 cycles.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_busy && n < 100) begin
      @(negedge clk);
      n++;
      checks++;
      if (rs1_dat !== 0 || rs2_dat !== 0 ||
          dbg_dat !== 0) begin
        errors++;
        $display("FAIL %s out_in_init rs1=%h rs2=%h dbg=%h want 0",
                 tag, rs1_dat, rs2_dat, dbg_dat);
      end
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL %s init_len got %0d want 32", tag, n);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [31:0] e1, e2, ed;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    ed = qd.pop_front();
    checks += 3;
    if (rs1_dat !== e1) begin
      errors++;
      $display("FAIL %s rs1 got %h want %h", tag, rs1_dat, e1);
    end
    if (rs2_dat !== e2) begin
      errors++;
      $display("FAIL %s rs2 got %h want %h", tag, rs2_dat, e2);
    end
    if (dbg_dat !== ed) begin
      errors++;
      $display("FAIL %s dbg got %h want %h", tag, dbg_dat, ed);
    end
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset busy got %b want 1", init_busy);
    end
    if (rs1_dat !== 0 || rs2_dat !== 0 || dbg_dat !== 0) begin
      errors++;
      $display("FAIL reset outs rs1=%h rs2=%h dbg=%h want 0",
               rs1_dat, rs2_dat, dbg_dat);
    end
    rs1_ren = 1; rs1_idx = 2; dbg_idx = 2;
    reset_n = 1;
    wait_init("init1");
    idle();
    model_init();
  endtask

  task automatic test_sp_and_zero();
    rs1_ren = 1; rs1_idx = 2;
    rs2_ren = 1; rs2_idx = 1;
    dbg_idx = 31;
    q1.push_back(SP); q2.push_back(0); qd.push_back(0);
    @(negedge clk);
    pop_cmp("sp_a");
    rs1_idx = 5; rs2_idx = 31; dbg_idx = 2;
    q1.push_back(0); q2.push_back(0); qd.push_back(SP);
    @(negedge clk);
    pop_cmp("sp_b");
    idle();
  endtask

  task automatic test_bypass();
    rd_wen = 1; rd_idx = 5; rd_dat = 32'hDEADBEEF;
    rs1_ren = 0; rs1_idx = 5;
    rs2_ren = 1; rs2_idx = 5;
    dbg_idx = 5;
    q1.push_back(0);
    q2.push_back(32'hDEADBEEF);
    qd.push_back(32'hDEADBEEF);
    @(negedge clk);
    m[5] = 32'hDEADBEEF;
    pop_cmp("bypass");
    rd_wen = 0;
    rs1_ren = 1; rs2_ren = 0; dbg_idx = 2;
    q1.push_back(32'hDEADBEEF);
    q2.push_back(32'hDEADBEEF);
    qd.push_back(SP);
    @(negedge clk);
    pop_cmp("wr_rd");
    idle();
  endtask

  task automatic test_x0();
    rd_wen = 1; rd_idx = 0; rd_dat = 32'h12345678;
    rs1_ren = 1; rs1_idx = 0;
    rs2_ren = 1; rs2_idx = 0;
    dbg_idx = 0;
    q1.push_back(0); q2.push_back(0); qd.push_back(0);
    @(negedge clk);
    pop_cmp("x0_bypass");
    rd_wen = 0;
    q1.push_back(0); q2.push_back(0); qd.push_back(0);
    @(negedge clk);
    pop_cmp("x0_read");
    idle();
  endtask

  task automatic test_ren_hold();
    rd_wen = 1; rd_idx = 7; rd_dat = 32'h11;
    @(negedge clk);
    m[7] = 32'h11;
    rd_wen = 0;
    rs1_ren = 1; rs1_idx = 7; dbg_idx = 7;
    q1.push_back(32'h11); q2.push_back(0);
    qd.push_back(32'h11);
    @(negedge clk);
    pop_cmp("hold_a");
    rs1_ren = 0;
    rd_wen = 1; rd_dat = 32'h22;
    q1.push_back(32'h11); q2.push_back(0);
    qd.push_back(32'h22);
    @(negedge clk);
    m[7] = 32'h22;
    pop_cmp("hold_b");
    rd_wen = 0;
    q1.push_back(32'h11); q2.push_back(0);
    qd.push_back(32'h22);
    @(negedge clk);
    pop_cmp("hold_c");
    rs1_ren = 1;
    q1.push_back(32'h22); q2.push_back(0);
    qd.push_back(32'h22);
    @(negedge clk);
    pop_cmp("hold_d");
    idle();
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 0;
    if (rd_wen && rd_idx == idx) return rd_dat;
    return m[idx];
  endfunction

  task automatic test_random();
    logic [31:0] l1, l2;
    l1 = rs1_dat_model();
    l2 = 0;
    for (int k = 0; k < 200; k++) begin
      rd_wen  = ($urandom_range(0, 1) == 1);
      rd_idx  = 5'($urandom_range(0, 7));
      rd_dat  = $urandom;
      rs1_ren = ($urandom_range(0, 3) != 0);
      rs1_idx = 5'($urandom_range(0, 7));
      rs2_ren = ($urandom_range(0, 3) != 0);
      rs2_idx = ($urandom_range(0, 3) == 0) ?
                rd_idx : 5'($urandom_range(0, 7));
      dbg_idx = 5'($urandom_range(0, 7));
      if (rs1_ren) l1 = exp_rd(rs1_idx);
      if (rs2_ren) l2 = exp_rd(rs2_idx);
      q1.push_back(l1); q2.push_back(l2);
      qd.push_back(exp_rd(dbg_idx));
      @(negedge clk);
      if (rd_wen && rd_idx != 0) m[rd_idx] = rd_dat;
      pop_cmp($sformatf("rand%0d", k));
    end
    idle();
  endtask

  function automatic logic [31:0] rs1_dat_model();
    return 32'h22;
  endfunction

  task automatic test_midinit_reset();
    rd_wen = 1; rd_idx = 9; rd_dat = 32'hA5A5A5A5;
    @(negedge clk);
    rd_wen = 0;
    rs1_ren = 1; rs1_idx = 9;
    rs2_ren = 1; rs2_idx = 9;
    dbg_idx = 9;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    checks += 2;
    if (rs1_dat !== 0 || rs2_dat !== 0 || dbg_dat !== 0) begin
      errors++;
      $display("FAIL async_rst outs rs1=%h rs2=%h dbg=%h want 0",
               rs1_dat, rs2_dat, dbg_dat);
    end
    if (init_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_rst busy got %b want 1", init_busy);
    end
    @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    #2 reset_n = 0;
    #1;
    checks++;
    if (init_busy !== 1'b1 || rs1_dat !== 0) begin
      errors++;
      $display("FAIL mid_rst busy=%b rs1=%h want 1/0",
               init_busy, rs1_dat);
    end
    @(negedge clk);
    rd_wen = 1; rd_idx = 3; rd_dat = 32'hFF;
    reset_n = 1;
    wait_init("init2");
    idle();
    model_init();
    rs1_ren = 1; rs1_idx = 9;
    rs2_ren = 1; rs2_idx = 3;
    dbg_idx = 7;
    q1.push_back(0); q2.push_back(0); qd.push_back(0);
    @(negedge clk);
    pop_cmp("post_a");
    rs1_idx = 5; rs2_idx = 2; dbg_idx = 3;
    q1.push_back(0); q2.push_back(SP); qd.push_back(0);
    @(negedge clk);
    pop_cmp("post_b");
    idle();
  endtask

  initial begin
    test_reset();
    test_sp_and_zero();
    test_bypass();
    test_x0();
    test_ren_hold();
    test_random();
    test_midinit_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
